// File: rtl/keypad_alarm_clock_pkg.sv
// Shared types, limits and lookup helpers for the keypad alarm clock.
// Holds slot/keypad tables, BCD digit limits and the seven-segment decoder.
package clock_pkg;

    typedef struct packed {
        logic [3:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
        logic [3:0] s1;
        logic [3:0] s0;
    } hms_t;

    localparam logic [3:0] LIM_H1_24   = 4'd2;
    localparam logic [3:0] LIM_H0_AT_2 = 4'd3;
    localparam logic [3:0] LIM_TENS    = 4'd5;
    localparam logic [3:0] LIM_DIG     = 4'd9;
    localparam logic [3:0] LIM_H1_12   = 4'd1;
    localparam logic [3:0] LIM_H0_AT_1 = 4'd2;

    localparam hms_t       HMS_ZERO = hms_t'(24'h000000);
    localparam hms_t       HMS_NOON = hms_t'(24'h120000);
    localparam logic [7:0] COM_OFF  = 8'hFF;

    function automatic logic [7:0] slot_com(input logic [2:0] s);
        case (s)
            3'd0:    return 8'b0111_1111;
            3'd1:    return 8'b1011_1111;
            3'd2:    return 8'b1101_1111;
            3'd3:    return 8'b1110_1111;
            3'd4:    return 8'b1111_0111;
            3'd5:    return 8'b1111_1011;
            default: return COM_OFF;
        endcase
    endfunction

    // Board wiring: bit 7 is the 9 key, bits 8/9 are 7/8.
    function automatic logic [3:0] key_digit(input logic [9:0] k);
        case (k)
            10'h001: return 4'd0;
            10'h002: return 4'd1;
            10'h004: return 4'd2;
            10'h008: return 4'd3;
            10'h010: return 4'd4;
            10'h020: return 4'd5;
            10'h040: return 4'd6;
            10'h080: return 4'd9;
            10'h100: return 4'd7;
            10'h200: return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] hms_get(input hms_t t, input logic [2:0] p);
        case (p)
            3'd0:    return t.h1;
            3'd1:    return t.h0;
            3'd2:    return t.m1;
            3'd3:    return t.m0;
            3'd4:    return t.s1;
            3'd5:    return t.s0;
            default: return 4'd0;
        endcase
    endfunction

    function automatic hms_t hms_put(input hms_t t, input logic [2:0] p, input logic [3:0] d);
        hms_t r;
        r = t;
        case (p)
            3'd0:    r.h1 = d;
            3'd1:    r.h0 = d;
            3'd2:    r.m1 = d;
            3'd3:    r.m0 = d;
            3'd4:    r.s1 = d;
            3'd5:    r.s0 = d;
            default: r = t;
        endcase
        return r;
    endfunction

    // h1 is the hours-tens digit already accepted at position 0.
    function automatic logic digit_ok(input logic [2:0] p, input logic [3:0] d,
                                      input logic [3:0] h1, input logic mode12);
        logic ok;
        case (p)
            3'd0: ok = mode12 ? (d <= LIM_H1_12) : (d <= LIM_H1_24);
            3'd1: begin
                if (mode12)
                    ok = (h1 == 4'd0) ? (d != 4'd0 && d <= LIM_DIG) : (d <= LIM_H0_AT_1);
                else
                    ok = (h1 == LIM_H1_24) ? (d <= LIM_H0_AT_2) : (d <= LIM_DIG);
            end
            3'd2, 3'd4: ok = (d <= LIM_TENS);
            default:    ok = (d <= LIM_DIG);
        endcase
        return ok;
    endfunction

    // Active-high segments, bit order dp,g,f,e,d,c,b,a.
    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 8'h3F;
            4'd1:    return 8'h06;
            4'd2:    return 8'h5B;
            4'd3:    return 8'h4F;
            4'd4:    return 8'h66;
            4'd5:    return 8'h6D;
            4'd6:    return 8'h7D;
            4'd7:    return 8'h07;
            4'd8:    return 8'h7F;
            4'd9:    return 8'h6F;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/keypad_alarm_clock_time.sv
// HH:MM:SS BCD time counter with load, 12 h / 24 h rollover and PM flag.
module bcd_time_counter import clock_pkg::*; #(
    parameter bit MODE_12H = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_i,
    input  logic load_i,
    input  hms_t load_val_i,
    output hms_t hms_o,
    output hms_t next_o,
    output logic pm_o
);

    localparam hms_t RST_VAL = MODE_12H ? HMS_NOON : HMS_ZERO;

    hms_t hms_q, hms_d;
    logic pm_q, pm_flip;

    always_comb begin
        hms_d   = hms_q;
        pm_flip = 1'b0;
        if (hms_q.s0 != LIM_DIG) hms_d.s0 = hms_q.s0 + 4'd1;
        else begin
            hms_d.s0 = 4'd0;
            if (hms_q.s1 != LIM_TENS) hms_d.s1 = hms_q.s1 + 4'd1;
            else begin
                hms_d.s1 = 4'd0;
                if (hms_q.m0 != LIM_DIG) hms_d.m0 = hms_q.m0 + 4'd1;
                else begin
                    hms_d.m0 = 4'd0;
                    if (hms_q.m1 != LIM_TENS) hms_d.m1 = hms_q.m1 + 4'd1;
                    else begin
                        hms_d.m1 = 4'd0;
                        if (MODE_12H) begin
                            // 12 -> 01 keeps the half; 11 -> 12 flips it.
                            if (hms_q.h1 == LIM_H1_12 && hms_q.h0 == LIM_H0_AT_1) begin
                                hms_d.h1 = 4'd0;
                                hms_d.h0 = 4'd1;
                            end else if (hms_q.h1 == LIM_H1_12 && hms_q.h0 == 4'd1) begin
                                hms_d.h0 = LIM_H0_AT_1;
                                pm_flip  = 1'b1;
                            end else if (hms_q.h0 == LIM_DIG) begin
                                hms_d.h1 = 4'd1;
                                hms_d.h0 = 4'd0;
                            end else hms_d.h0 = hms_q.h0 + 4'd1;
                        end else begin
                            if (hms_q.h1 == LIM_H1_24 && hms_q.h0 == LIM_H0_AT_2) begin
                                hms_d.h1 = 4'd0;
                                hms_d.h0 = 4'd0;
                            end else if (hms_q.h0 == LIM_DIG) begin
                                hms_d.h1 = hms_q.h1 + 4'd1;
                                hms_d.h0 = 4'd0;
                            end else hms_d.h0 = hms_q.h0 + 4'd1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hms_q <= RST_VAL;
            pm_q  <= 1'b0;
        end else if (load_i) begin
            hms_q <= load_val_i;
            pm_q  <= 1'b0;
        end else if (tick_i) begin
            hms_q <= hms_d;
            pm_q  <= pm_q ^ pm_flip;
        end
    end

    assign hms_o  = hms_q;
    assign next_o = hms_d;
    assign pm_o   = pm_q;

endmodule

// File: rtl/keypad_alarm_clock.sv
// Keypad-set digital clock with alarm, driving a 6-digit multiplexed 7-segment board.
// Entry goes through a shadow buffer; commits land in the time counter or alarm register.
module keypad_alarm_clock import clock_pkg::*; #(
    parameter int TICKS_PER_SEC = 1000,
    parameter int SCAN_DIV      = 1,
    parameter int BLINK_TICKS   = 250,
    parameter int ENTRY_TIMEOUT = 5000,
    parameter int ALARM_SECS    = 30,
    parameter int MODE_12H      = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_mode,
    input  logic       alarm_sel,
    input  logic       alarm_en,
    input  logic [9:0] keypad,
    output logic [7:0] seg_data,
    output logic [7:0] seg_com,
    output logic       pm,
    output logic       time_valid,
    output logic       alarm_out,
    output logic       key_err
);

    localparam bit M12 = (MODE_12H != 0);
    localparam int TW  = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int DW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW  = $clog2(2 * BLINK_TICKS);
    localparam int EW  = $clog2(ENTRY_TIMEOUT + 1);
    localparam int AW  = $clog2(ALARM_SECS + 1);
    localparam hms_t RST_HMS = M12 ? HMS_NOON : HMS_ZERO;

    logic [9:0]    key_prev_q;
    logic          set_mode_q, alarm_sel_q;
    hms_t          buf_q, buf_d, alarm_q;
    logic [2:0]    pos_q, pos_d;
    logic [EW-1:0] idle_q, idle_d;
    logic          key_err_q, alarm_valid_q, time_valid_q, alarm_out_q;
    logic [TW-1:0] sec_cnt_q;
    logic [AW-1:0] ring_q;
    logic [BW-1:0] blink_q;
    logic [DW-1:0] div_q;
    logic [2:0]    slot_q;
    logic [7:0]    seg_data_q, seg_data_d, seg_com_q;

    logic       key_hot, key_press, timeout, abort, entry, dig_ok;
    logic       accept, reject, commit, load_time, load_alarm;
    logic       run, tick, trigger, ring_clr, blank;
    logic [3:0] key_dig;
    hms_t       commit_val, time_hms, time_next, src;
    logic       cnt_pm;

    assign key_hot    = (keypad != 10'd0) && ((keypad & (keypad - 10'd1)) == 10'd0);
    assign key_press  = key_hot && (key_prev_q == 10'd0);
    assign key_dig    = key_digit(keypad);
    assign timeout    = set_mode && (pos_q != 3'd0) && !key_press
                        && (idle_q == EW'(ENTRY_TIMEOUT - 1));
    assign abort      = (set_mode_q && !set_mode) || (alarm_sel_q != alarm_sel) || timeout;
    assign entry      = set_mode && key_press && !abort;
    assign dig_ok     = digit_ok(pos_q, key_dig, buf_q.h1, M12);
    assign accept     = entry && dig_ok;
    assign reject     = entry && !dig_ok;
    assign commit     = accept && (pos_q == 3'd5);
    assign commit_val = hms_put(buf_q, pos_q, key_dig);
    assign load_time  = commit && !alarm_sel;
    assign load_alarm = commit && alarm_sel;

    // Time entry freezes the clock; alarm entry lets it keep running.
    assign run      = time_valid_q && !(set_mode && !alarm_sel);
    assign tick     = run && (sec_cnt_q == TW'(TICKS_PER_SEC - 1)) && !load_time;
    assign trigger  = tick && (time_next == alarm_q) && alarm_en && alarm_valid_q;
    assign ring_clr = key_press || !alarm_en
                      || (alarm_out_q && tick && (ring_q == AW'(ALARM_SECS - 1)));

    bcd_time_counter #(.MODE_12H(M12)) u_time (
        .clk       (clk),
        .rst       (rst),
        .tick_i    (tick),
        .load_i    (load_time),
        .load_val_i(commit_val),
        .hms_o     (time_hms),
        .next_o    (time_next),
        .pm_o      (cnt_pm)
    );

    always_comb begin
        buf_d  = buf_q;
        pos_d  = pos_q;
        idle_d = '0;
        if (set_mode && pos_q != 3'd0 && !key_press && !abort)
            idle_d = idle_q + EW'(1);
        if (abort) pos_d = 3'd0;
        else if (accept) begin
            buf_d = commit_val;
            pos_d = commit ? 3'd0 : pos_q + 3'd1;
        end
    end

    // Digits left of the cursor come from the buffer, the rest from the target.
    always_comb begin
        if (!set_mode)           src = time_hms;
        else if (slot_q < pos_q) src = buf_q;
        else if (alarm_sel)      src = alarm_q;
        else                     src = time_hms;
        blank      = set_mode && (slot_q == pos_q) && (blink_q >= BW'(BLINK_TICKS));
        seg_data_d = (slot_q >= 3'd6 || blank) ? 8'h00 : seg_decode(hms_get(src, slot_q));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_prev_q    <= '0;
            set_mode_q    <= 1'b0;
            alarm_sel_q   <= 1'b0;
            buf_q         <= RST_HMS;
            pos_q         <= '0;
            idle_q        <= '0;
            key_err_q     <= 1'b0;
            alarm_q       <= RST_HMS;
            alarm_valid_q <= 1'b0;
            time_valid_q  <= 1'b0;
            sec_cnt_q     <= '0;
            ring_q        <= '0;
            alarm_out_q   <= 1'b0;
            blink_q       <= '0;
            div_q         <= '0;
            slot_q        <= '0;
            seg_data_q    <= 8'h00;
            seg_com_q     <= COM_OFF;
        end else begin
            key_prev_q  <= keypad;
            set_mode_q  <= set_mode;
            alarm_sel_q <= alarm_sel;
            buf_q       <= buf_d;
            pos_q       <= pos_d;
            idle_q      <= idle_d;
            key_err_q   <= reject;

            if (load_alarm) begin
                alarm_q       <= commit_val;
                alarm_valid_q <= 1'b1;
            end
            if (load_time) begin
                time_valid_q <= 1'b1;
                sec_cnt_q    <= '0;
            end else if (run) begin
                sec_cnt_q <= (sec_cnt_q == TW'(TICKS_PER_SEC - 1)) ? '0 : sec_cnt_q + TW'(1);
            end

            if (ring_clr) alarm_out_q <= 1'b0;
            else if (trigger) alarm_out_q <= 1'b1;
            if (trigger) ring_q <= '0;
            else if (alarm_out_q && tick) ring_q <= ring_q + AW'(1);

            blink_q <= (blink_q == BW'(2 * BLINK_TICKS - 1)) ? '0 : blink_q + BW'(1);
            if (div_q == DW'(SCAN_DIV - 1)) begin
                div_q  <= '0;
                slot_q <= slot_q + 3'd1;
            end else begin
                div_q <= div_q + DW'(1);
            end
            seg_data_q <= seg_data_d;
            seg_com_q  <= slot_com(slot_q);
        end
    end

    assign seg_data   = seg_data_q;
    assign seg_com    = seg_com_q;
    assign pm         = M12 ? cnt_pm : 1'b0;
    assign time_valid = time_valid_q;
    assign alarm_out  = alarm_out_q;
    assign key_err    = key_err_q;

endmodule

// File: tb/tb_keypad_alarm_clock.sv
// Directed bench: a 24 h and a 12 h instance share the board inputs.
module tb_keypad_alarm_clock;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       set_mode = 1'b0;
    logic       alarm_sel = 1'b0;
    logic       alarm_en = 1'b0;
    logic [9:0] keypad = '0;

    logic [7:0] sd_a, sc_a, sd_b, sc_b;
    logic       pm_a, pm_b, tv_a, tv_b, al_a, al_b, ke_a, ke_b;
    logic [23:0] ta, tb;
    logic [2:0]  pos_a, pos_b;
    logic        ke_a_s, ke_b_s, al_s;
    logic [7:0]  com_tab [0:7];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    keypad_alarm_clock #(
        .TICKS_PER_SEC(4), .SCAN_DIV(2), .BLINK_TICKS(3),
        .ENTRY_TIMEOUT(30), .ALARM_SECS(3), .MODE_12H(0)
    ) dut_a (
        .clk(clk), .rst(rst), .set_mode(set_mode), .alarm_sel(alarm_sel),
        .alarm_en(alarm_en), .keypad(keypad), .seg_data(sd_a), .seg_com(sc_a),
        .pm(pm_a), .time_valid(tv_a), .alarm_out(al_a), .key_err(ke_a)
    );

    keypad_alarm_clock #(
        .TICKS_PER_SEC(4), .SCAN_DIV(1), .BLINK_TICKS(3),
        .ENTRY_TIMEOUT(30), .ALARM_SECS(3), .MODE_12H(1)
    ) dut_b (
        .clk(clk), .rst(rst), .set_mode(set_mode), .alarm_sel(alarm_sel),
        .alarm_en(alarm_en), .keypad(keypad), .seg_data(sd_b), .seg_com(sc_b),
        .pm(pm_b), .time_valid(tv_b), .alarm_out(al_b), .key_err(ke_b)
    );

    assign ta    = dut_a.time_hms;
    assign tb    = dut_b.time_hms;
    assign pos_a = dut_a.pos_q;
    assign pos_b = dut_b.pos_q;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] kcode(input int d);
        logic [9:0] one;
        one = 10'd1;
        case (d)
            7:       return 10'h100;
            8:       return 10'h200;
            9:       return 10'h080;
            default: return one << d;
        endcase
    endfunction

    // One press: key held two cycles, then released for one; ends at posedge+1.
    task automatic key(input int d);
        keypad = kcode(d);
        @(posedge clk); @(negedge clk);
        ke_a_s = ke_a;
        ke_b_s = ke_b;
        al_s   = al_a;
        @(posedge clk); #1 keypad = '0;
        @(posedge clk); #1;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        com_tab = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFF, 8'hFF};
        set_mode = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_com_a", 32'(sc_a), 32'hFF);
        chk("rst_dat_a", 32'(sd_a), 32'h00);
        chk("rst_alm_a", 32'(al_a), 32'h0);
        chk("rst_pm_a", 32'(pm_a), 32'h0);
        chk("rst_tv_a", 32'(tv_a), 32'h0);
        chk("rst_err_a", 32'(ke_a), 32'h0);
        chk("rst_com_b", 32'(sc_b), 32'hFF);
        chk("rst_dat_b", 32'(sd_b), 32'h00);
        chk("rst_misc_b", 32'({tv_b, al_b, pm_b}), 32'h0);
        @(posedge clk); #1 rst = 1'b1;

        // Scan order, blank slots 6-7, cursor blink on slot 0 (period 6, scan period 16).
        for (int k = 1; k <= 40; k++) begin
            int slot;
            logic [7:0] exp_d;
            @(posedge clk); @(negedge clk);
            slot  = ((k - 1) / 2) % 8;
            exp_d = (slot >= 6 || (slot == 0 && ((k - 1) % 6) >= 3)) ? 8'h00 : 8'h3F;
            chk("scan_com", 32'(sc_a), 32'(com_tab[slot]));
            chk("scan_dat", 32'(sd_a), 32'(exp_d));
        end
        @(posedge clk); #1;
        chk("init_time_a", 32'(ta), 32'h000000);
        chk("init_time_b", 32'(tb), 32'h120000);

        // Time entry 23:59:58, then 8 ticks across midnight.
        key(2); key(3); key(5); key(9); key(5);
        chk("pos_before_commit", 32'(pos_a), 32'd5);
        key(8);
        chk("commit_pos", 32'(pos_a), 32'd0);
        chk("commit_time", 32'(ta), 32'h235958);
        chk("time_valid", 32'(tv_a), 32'h1);
        set_mode = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("count_7ticks", 32'(ta), 32'h000005);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("count_8ticks", 32'(ta), 32'h000006);
        @(posedge clk); #1 set_mode = 1'b1;

        // Digit validation.
        key(2); chk("key2_err", 32'(ke_a_s), 32'h0);
        key(4); chk("key4_err", 32'(ke_a_s), 32'h1);
        chk("key4_pos", 32'(pos_a), 32'd1);
        key(3); chk("key3_err", 32'(ke_a_s), 32'h0);
        chk("key3_pos", 32'(pos_a), 32'd2);
        key(7); chk("key7_err", 32'(ke_a_s), 32'h1);
        chk("key7_pos", 32'(pos_a), 32'd2);
        chk("err_pulse_end", 32'(ke_a), 32'h0);
        set_mode = 1'b0;
        cyc(1);
        chk("abort_mode_pos", 32'(pos_a), 32'd0);
        chk("abort_mode_time", 32'(ta), 32'h000006);
        set_mode = 1'b1;

        // Idle timeout discards a partial entry.
        key(1); key(2); key(3);
        chk("to_pos3", 32'(pos_a), 32'd3);
        cyc(10);
        chk("to_still3", 32'(pos_a), 32'd3);
        cyc(30);
        chk("to_pos0", 32'(pos_a), 32'd0);
        chk("to_time", 32'(ta), 32'h000006);

        // Alarm 00:00:05, time 00:00:03.
        alarm_sel = 1'b1;
        cyc(1);
        key(0); key(0); key(0); key(0); key(0); key(5);
        chk("alarm_reg", 32'(dut_a.alarm_q), 32'h000005);
        alarm_sel = 1'b0;
        cyc(1);
        key(0); key(0); key(0); key(0); key(0); key(3);
        chk("alm_time_set", 32'(ta), 32'h000003);
        alarm_en = 1'b1;
        set_mode = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        chk("alm_before", 32'(al_a), 32'h0);
        @(posedge clk); @(negedge clk);
        chk("alm_rise", 32'(al_a), 32'h1);
        chk("alm_rise_time", 32'(ta), 32'h000005);
        repeat (11) @(posedge clk);
        @(negedge clk);
        chk("alm_hold", 32'(al_a), 32'h1);
        @(posedge clk); @(negedge clk);
        chk("alm_expire", 32'(al_a), 32'h0);

        // Key press mid-ring.
        @(posedge clk); #1 set_mode = 1'b1;
        key(0); key(0); key(0); key(0); key(0); key(3);
        set_mode = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("ring2_rise", 32'(al_a), 32'h1);
        @(posedge clk); #1;
        key(1);
        chk("ring2_key_clr", 32'(al_s), 32'h0);

        // Reset mid-scan acts immediately.
        rst = 1'b0;
        #1;
        chk("rst_mid_com_a", 32'(sc_a), 32'hFF);
        chk("rst_mid_dat_a", 32'(sd_a), 32'h00);
        chk("rst_mid_tv_a", 32'(tv_a), 32'h0);
        chk("rst_mid_time_a", 32'(ta), 32'h000000);
        chk("rst_mid_com_b", 32'(sc_b), 32'hFF);
        cyc(2);
        rst = 1'b1;
        set_mode = 1'b1;
        cyc(1);
        chk("b_reset_time", 32'(tb), 32'h120000);
        chk("b_reset_pm", 32'(pm_b), 32'h0);

        // 12 h digit validation.
        key(2); chk("b_h1_2_err", 32'(ke_b_s), 32'h1);
        key(0); chk("b_h1_0_err", 32'(ke_b_s), 32'h0);
        key(0); chk("b_h0_0_err", 32'(ke_b_s), 32'h1);
        key(9); chk("b_h0_9_err", 32'(ke_b_s), 32'h0);
        chk("b_pos2", 32'(pos_b), 32'd2);
        set_mode = 1'b0;
        cyc(1);
        set_mode = 1'b1;
        cyc(1);
        chk("b_abort_pos", 32'(pos_b), 32'd0);

        // 11:59:59 -> 12:00:00 PM.
        key(1); key(1); key(5); key(9); key(5); key(9);
        chk("b_load_11", 32'(tb), 32'h115959);
        chk("b_tv", 32'(tv_b), 32'h1);
        set_mode = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("b_noon", 32'(tb), 32'h120000);
        chk("b_noon_pm", 32'(pm_b), 32'h1);

        // 12:59:59 -> 01:00:00, entry clears PM.
        @(posedge clk); #1 set_mode = 1'b1;
        key(1); key(2); key(5); key(9); key(5); key(9);
        chk("b_load_12", 32'(tb), 32'h125959);
        chk("b_load_pm", 32'(pm_b), 32'h0);
        set_mode = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("b_one", 32'(tb), 32'h010000);
        chk("b_one_pm", 32'(pm_b), 32'h0);
        chk("a_pm_24h", 32'(pm_a), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
